// File: rtl/burst_ram_pkg.sv
// Shared opcode and FSM state types for the burst RAM command interface.
package burst_ram_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_SET_WADDR = 2'b00,
        OP_WRITE     = 2'b01,
        OP_SET_RADDR = 2'b10,
        OP_READ      = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RD   = 1'b1
    } state_e;

endpackage

// File: rtl/burst_ram_array.sv
// Single write port, single synchronous read port storage; read register holds until re.
module burst_ram_array #(
    parameter int unsigned W      = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [W-1:0] mem [DEPTH];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/burst_ram.sv
// Command-driven RAM: pointer loads, writes and read bursts streamed over a valid/ready port.
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int unsigned W           = 8,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned CNT_W       = 4,
    parameter bit          WR_AUTO_INC = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W+1:0] din,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic [W-1:0] dout,
    output logic         tx_valid,
    input  logic         tx_ready
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic                tx_valid_q, tx_valid_d;
    logic                we, re;
    logic [ADDR_W-1:0]   raddr;
    op_e                 op;

    assign op       = op_e'(din[W+1:W]);
    assign rx_ready = (state_q == ST_IDLE);
    assign tx_valid = tx_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            rem_q      <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rem_q      <= rem_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    // Command decode in IDLE; beat sequencing in RD prefetches the next word on consumption.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rem_d      = rem_q;
        tx_valid_d = tx_valid_q;
        we         = 1'b0;
        re         = 1'b0;
        raddr      = rptr_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (op)
                        OP_SET_WADDR: wptr_d = din[ADDR_W-1:0];
                        OP_WRITE: begin
                            we = 1'b1;
                            if (WR_AUTO_INC) begin
                                wptr_d = wptr_q + ADDR_W'(1);
                            end
                        end
                        OP_SET_RADDR: rptr_d = din[ADDR_W-1:0];
                        OP_READ: begin
                            re         = 1'b1;
                            tx_valid_d = 1'b1;
                            rem_d      = din[CNT_W-1:0];
                            state_d    = ST_RD;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RD: begin
                if (tx_ready) begin
                    rptr_d = rptr_q + ADDR_W'(1);
                    if (rem_q != '0) begin
                        re    = 1'b1;
                        raddr = rptr_q + ADDR_W'(1);
                        rem_d = rem_q - CNT_W'(1);
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    burst_ram_array #(
        .W      (W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (wptr_q),
        .wdata (din[W-1:0]),
        .re    (re),
        .raddr (raddr),
        .rdata (dout)
    );

endmodule

// File: tb/tb_burst_ram.sv
// Directed bench for burst_ram with a queue scoreboard checking every consumed beat.
module tb_burst_ram;

    localparam logic [1:0] SET_WADDR = 2'b00;
    localparam logic [1:0] WRITE     = 2'b01;
    localparam logic [1:0] SET_RADDR = 2'b10;
    localparam logic [1:0] READ      = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] dout;
    logic       tx_valid;
    logic       tx_ready;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];

    burst_ram #(
        .W           (8),
        .ADDR_W      (8),
        .CNT_W       (4),
        .WR_AUTO_INC (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .dout     (dout),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got %h expected none", dout);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {8'h00, dout}, {8'h00, e});
                end
            end
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] f);
        int t = 0;
        while (rx_ready !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (rx_ready !== 1'b1) chk("send_wait_ready", {15'h0, rx_ready}, 16'h1);
        din      = {op, f};
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((tx_valid !== 1'b0 || rx_ready !== 1'b1) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("wait_idle", {15'h0, rx_ready & ~tx_valid}, 16'h1);
    endtask

    initial begin
        rst_n    = 1'b0;
        din      = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        fork
            monitor_loop();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_valid", {15'h0, tx_valid}, 16'h0);
        chk("rst_dout", {8'h00, dout}, 16'h00);
        chk("rst_rx_ready", {15'h0, rx_ready}, 16'h1);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk); #1;

        // Single beat with one-cycle latency
        send(SET_WADDR, 8'h10);
        send(WRITE, 8'hA5);
        send(SET_RADDR, 8'h10);
        exp_q.push_back(8'hA5);
        send(READ, 8'h00);
        chk("single_tx_valid", {15'h0, tx_valid}, 16'h1);
        chk("single_dout", {8'h00, dout}, 16'hA5);
        @(posedge clk); #1;
        chk("single_done_tx_valid", {15'h0, tx_valid}, 16'h0);
        chk("single_done_rx_ready", {15'h0, rx_ready}, 16'h1);

        // Pointer wrap and back-to-back burst, then sequential continuation at 01
        send(SET_WADDR, 8'h01);
        send(WRITE, 8'hC3);
        send(SET_WADDR, 8'hFE);
        send(WRITE, 8'h11);
        send(WRITE, 8'h22);
        send(WRITE, 8'h33);
        send(SET_RADDR, 8'hFE);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        send(READ, 8'h02);
        for (int i = 0; i < 3; i++) begin
            chk("burst_no_bubble", {15'h0, tx_valid}, 16'h1);
            @(posedge clk); #1;
        end
        chk("burst_end_tx_valid", {15'h0, tx_valid}, 16'h0);
        exp_q.push_back(8'hC3);
        send(READ, 8'h00);
        wait_idle();

        // Backpressure on beat 2
        send(SET_WADDR, 8'h20);
        send(WRITE, 8'h01);
        send(WRITE, 8'h02);
        send(WRITE, 8'h03);
        send(WRITE, 8'h04);
        send(SET_RADDR, 8'h20);
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        send(READ, 8'h03);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_dout", {8'h00, dout}, 16'h02);
            chk("stall_tx_valid", {15'h0, tx_valid}, 16'h1);
        end
        tx_ready = 1'b1;
        wait_idle();

        // Command dropped while busy
        send(SET_WADDR, 8'h55);
        send(WRITE, 8'h9A);
        send(WRITE, 8'h9B);
        send(SET_WADDR, 8'h60);
        send(SET_RADDR, 8'h20);
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        send(READ, 8'h03);
        din      = {SET_WADDR, 8'h55};
        rx_valid = 1'b1;
        chk("busy_rx_ready", {15'h0, rx_ready}, 16'h0);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        wait_idle();
        send(WRITE, 8'h77);
        send(SET_RADDR, 8'h55);
        exp_q.push_back(8'h9A);
        send(READ, 8'h00);
        wait_idle();
        send(SET_RADDR, 8'h60);
        exp_q.push_back(8'h77);
        send(READ, 8'h00);
        wait_idle();

        // Reset mid-burst after beat 1
        send(SET_RADDR, 8'h20);
        exp_q.push_back(8'h01);
        send(READ, 8'h03);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_tx_valid", {15'h0, tx_valid}, 16'h0);
        chk("rstmid_rx_ready", {15'h0, rx_ready}, 16'h1);
        chk("rstmid_dout", {8'h00, dout}, 16'h00);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(8'h33);
        send(READ, 8'h00);
        wait_idle();
        send(WRITE, 8'h5C);
        send(SET_RADDR, 8'h00);
        exp_q.push_back(8'h5C);
        send(READ, 8'h00);
        wait_idle();
        send(SET_RADDR, 8'h20);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        send(READ, 8'h01);
        wait_idle();

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 16'(exp_q.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/burst_ram.md
BURST_RAM -- requirements
Module: burst_ram

Interface
REQ-001 SHALL have parameter W, default 8: data field width and memory word width.
REQ-002 SHALL have parameter ADDR_W, default 8: address width, with ADDR_W <= W and DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter CNT_W, default 4: read-burst length field width, with CNT_W <= W.
REQ-004 SHALL have parameter WR_AUTO_INC, default 1: when 1, the write pointer advances after each write.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port din  input  W+2  command word: din[W+1:W] opcode, din[W-1:0] field.
REQ-008 SHALL have port rx_valid  input  1  din valid.
REQ-009 SHALL have port rx_ready  output  1  block can accept a command.
REQ-010 SHALL have port dout  output  W  read data beat.
REQ-011 SHALL have port tx_valid  output  1  dout valid.
REQ-012 SHALL have port tx_ready  input  1  consumer accepts the dout beat.

Function
REQ-013 A command SHALL be accepted only in a cycle with rx_valid=1 and rx_ready=1; a command with rx_valid=1 and rx_ready=0 SHALL be dropped with no effect.
REQ-014 Opcode 00 (SET_WADDR) SHALL load wptr <= din[ADDR_W-1:0].
REQ-015 Opcode 01 (WRITE) SHALL write mem[wptr] <= din[W-1:0]; if WR_AUTO_INC=1, wptr SHALL advance by 1 modulo DEPTH (FF->00 at ADDR_W=8).
REQ-016 Opcode 10 (SET_RADDR) SHALL load rptr <= din[ADDR_W-1:0].
REQ-017 Opcode 11 (READ) SHALL start a burst of len = din[CNT_W-1:0]+1 beats (1..2**CNT_W) from rptr.
REQ-018 The FSM SHALL have two states: IDLE, which moves to RD on an accepted READ, and RD, which moves to IDLE when the last beat is consumed.
REQ-019 rx_ready SHALL be 1 exactly when the state is IDLE, decoded from the state register.
REQ-020 In the READ accept cycle the block SHALL register dout <= mem[rptr], tx_valid <= 1 and remaining <= len-1; the first beat appears 1 cycle after acceptance.
REQ-021 A beat SHALL be consumed on tx_valid=1 and tx_ready=1; rptr SHALL then advance by 1 modulo DEPTH.
REQ-022 On consumption with remaining>0, the next cycle SHALL present dout = mem[rptr+1] with tx_valid=1, giving back-to-back beats with no bubble.
REQ-023 On consumption with remaining=0, the next cycle SHALL present tx_valid=0, state IDLE and rx_ready=1.
REQ-024 While tx_valid=1 and tx_ready=0, dout, tx_valid, rptr and remaining SHALL be held stable.
REQ-025 When tx_valid=0, dout SHALL retain its last value.
REQ-026 After a burst, rptr SHALL equal start+len modulo DEPTH, so a following READ continues sequentially.

Reset
REQ-027 When rst_n=0 at a clock edge: tx_valid=0, dout=0, wptr=0, rptr=0, remaining=0 and state=IDLE (rx_ready=1) from that edge.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Reset during a burst SHALL abort the burst with no further beats; writes accepted before reset SHALL persist.

Structure
REQ-030 Package burst_ram_pkg SHALL hold the opcode enum (OP_SET_WADDR, OP_WRITE, OP_SET_RADDR, OP_READ) and the state typedef (ST_IDLE, ST_RD).
REQ-031 Storage SHALL be one sub-module, burst_ram_array, with one write port and one synchronous read port; the top holds the FSM, pointers and handshake.

Verification (W=8, ADDR_W=8, CNT_W=4)
REQ-032 Reset: rst_n=0 for 2 cycles -> tx_valid=0, dout=00, rx_ready=1.
REQ-033 Single beat: din 0_10, 1_A5, 2_10, 3_00 -> tx_valid=1 and dout=A5 one cycle after READ; with tx_ready=1 -> next cycle tx_valid=0, rx_ready=1.
REQ-034 Wrap and burst: SET_WADDR FE, WRITE 11, 22, 33; SET_RADDR FE; READ 02 with tx_ready=1 -> dout 11, 22, 33 on consecutive cycles, then rptr=01.
REQ-035 Backpressure: 4-beat burst with tx_ready=0 for 3 cycles after beat 2 -> dout and tx_valid frozen, all 4 beats delivered in order, none skipped or duplicated.
REQ-036 Busy drop: SET_WADDR 55 issued mid-burst (rx_ready=0), then WRITE 77 after the burst -> 77 lands at the old wptr and mem[55] is unchanged.
REQ-037 Reset mid-burst: rst_n=0 after beat 1 of 4 -> tx_valid=0 and rx_ready=1 at the next edge; a later read returns the previously written data.
